// File: rtl/cpu_dma_req_sched.sv
// Round-robin scheduler sharing one DMA channel between peripheral requesters.
// Grants one requester at a time, then pulses its clear and holds it off.
module cpu_dma_req_sched #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_sreq,
  input  logic [NUM_REQ-1:0] i_breq,
  input  logic [NUM_REQ-1:0] i_req_en,
  output logic [NUM_REQ-1:0] o_dmaclr,
  output logic               o_dma_req,
  output logic [SEL_W-1:0]   o_dma_sel,
  output logic               o_dma_burst,
  input  logic               i_dma_ack,
  input  logic               i_dma_done,
  output logic               o_busy,
  output logic               o_timeout,
  input  logic               i_timeout_clr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    CLR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   grant;
  logic               burst;
  logic               found;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] sel_oh;
  logic [3:0]         hcnt;
  logic [15:0]        tcnt;
  logic               tmo_hit;
  logic               tmo_set;

  logic [NUM_REQ-1:0] clr_nx;
  logic               req_nx;
  logic               busy_nx;

  assign elig    = (i_sreq | i_breq) & i_req_en & ~mask;
  assign sel_oh  = NUM_REQ'(1) << sel;
  assign tmo_hit = (state == XFER) && (tcnt == 16'(TIMEOUT));
  assign tmo_set = (state == XFER) && !i_dma_done
                && (tcnt == 16'(TIMEOUT - 1));

  // Search starts one past the last grant and wraps.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && elig[SEL_W'(idx)]) begin
        found = 1'b1;
        grant = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (found) state_nx = REQ;
      REQ: begin
        if (i_dma_ack)
          state_nx = i_dma_done ? CLR : XFER;
      end
      XFER: begin
        if (i_dma_done || tmo_hit)
          state_nx = CLR;
      end
      CLR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clr_nx  = '0;
    req_nx  = 1'b0;
    busy_nx = 1'b1;
    unique case (1'b1)
      (state_nx == IDLE): busy_nx = 1'b0;
      (state_nx == REQ):  req_nx  = 1'b1;
      (state_nx == CLR):  clr_nx  = sel_oh;
      default:            busy_nx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= SEL_W'(NUM_REQ - 1);
      sel       <= '0;
      burst     <= 1'b0;
      mask      <= '0;
      hcnt      <= '0;
      tcnt      <= '0;
      o_dmaclr  <= '0;
      o_dma_req <= 1'b0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      o_dmaclr  <= clr_nx;
      o_dma_req <= req_nx;
      o_busy    <= busy_nx;
      if (state == IDLE && found) begin
        sel   <= grant;
        ptr   <= grant;
        burst <= i_breq[grant];
      end
      tcnt <= (state == XFER) ? tcnt + 16'd1 : '0;
      // Only the most recently served requester is held off.
      if (state == CLR) begin
        hcnt <= 4'(HOLDOFF);
        mask <= sel_oh;
      end else if (hcnt != '0) begin
        hcnt <= hcnt - 4'd1;
        if (hcnt == 4'd1)
          mask <= '0;
      end
      if (tmo_set)
        o_timeout <= 1'b1;
      else if (i_timeout_clr)
        o_timeout <= 1'b0;
    end
  end

  assign o_dma_sel   = sel;
  assign o_dma_burst = burst;

endmodule

// File: tb/tb_cpu_dma_req_sched.sv
// Directed bench for cpu_dma_req_sched: vector table plus
// hand-written holdoff, timeout and mid-transfer reset sequences.
module tb_cpu_dma_req_sched;

  logic       clk;
  logic       rst;
  logic [3:0] sreq;
  logic [3:0] breq;
  logic [3:0] en;
  logic [3:0] dmaclr;
  logic       dma_req;
  logic [1:0] dma_sel;
  logic       dma_burst;
  logic       ack;
  logic       done;
  logic       busy;
  logic       tmo;
  logic       tclr;

  int ncmp;
  int nfail;

  typedef struct {
    logic       rst;
    logic [3:0] sreq;
    logic [3:0] breq;
    logic [3:0] en;
    logic       ack;
    logic       done;
    logic [3:0] clr;
    logic       req;
    logic [1:0] sel;
    logic       burst;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vq[$];

  cpu_dma_req_sched #(
    .NUM_REQ(4),
    .SEL_W  (2),
    .HOLDOFF(2),
    .TIMEOUT(8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sreq       (sreq),
    .i_breq       (breq),
    .i_req_en     (en),
    .o_dmaclr     (dmaclr),
    .o_dma_req    (dma_req),
    .o_dma_sel    (dma_sel),
    .o_dma_burst  (dma_burst),
    .i_dma_ack    (ack),
    .i_dma_done   (done),
    .o_busy       (busy),
    .o_timeout    (tmo),
    .i_timeout_clr(tclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(
    input logic r, input logic [3:0] s, input logic [3:0] b,
    input logic [3:0] e, input logic a, input logic d,
    input logic [3:0] c, input logic q, input logic [1:0] sl,
    input logic bu, input logic by, input logic t);
    vec_t v;
    v.rst = r; v.sreq = s; v.breq = b; v.en = e;
    v.ack = a; v.done = d; v.clr = c; v.req = q;
    v.sel = sl; v.burst = bu; v.busy = by; v.to = t;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sreq = '0; breq = '0; en = 4'hF;
    ack = 1'b0; done = 1'b0; tclr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] act;
    logic [9:0] exp;
    ncmp = 0;
    nfail = 0;
    rst = 1'b1; sreq = '0; breq = '0; en = 4'hF;
    ack = 1'b0; done = 1'b0; tclr = 1'b0;

    // single request, separate ack and done
    add(1, 4'h0, 4'h0, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'h1, 4'h0, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'h1, 4'h0, 4'hF, 1, 0, 4'h0, 1, 0, 0, 1, 0);
    add(0, 4'h0, 4'h0, 4'hF, 0, 1, 4'h0, 0, 0, 0, 1, 0);
    add(0, 4'h0, 4'h0, 4'hF, 0, 0, 4'h1, 0, 0, 0, 1, 0);
    add(0, 4'h0, 4'h0, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    // all burst requests held: order 0,1,2,3,0
    add(1, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 4'hF, 4'hF, 1, 1, 4'h0, 1, 0, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h1, 0, 0, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 4'hF, 4'hF, 1, 1, 4'h0, 1, 1, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h2, 0, 1, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 1, 1, 0, 0);
    add(0, 4'h0, 4'hF, 4'hF, 1, 1, 4'h0, 1, 2, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h4, 0, 2, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 2, 1, 0, 0);
    add(0, 4'h0, 4'hF, 4'hF, 1, 1, 4'h0, 1, 3, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h8, 0, 3, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 3, 1, 0, 0);
    add(0, 4'h0, 4'hF, 4'hF, 1, 1, 4'h0, 1, 0, 1, 1, 0);
    add(0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h1, 0, 0, 1, 1, 0);
    // requester 1 disabled, all single requests high
    add(1, 4'hF, 4'h0, 4'hD, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    add(0, 4'hF, 4'h0, 4'hD, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 4'h0, 4'hD, 1, 1, 4'h0, 1, 0, 0, 1, 0);
    add(0, 4'hF, 4'h0, 4'hD, 0, 0, 4'h1, 0, 0, 0, 1, 0);
    add(0, 4'hF, 4'h0, 4'hD, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 4'h0, 4'hD, 1, 1, 4'h0, 1, 2, 0, 1, 0);
    add(0, 4'hF, 4'h0, 4'hD, 0, 0, 4'h4, 0, 2, 0, 1, 0);
    add(0, 4'hF, 4'h0, 4'hD, 0, 0, 4'h0, 0, 2, 0, 0, 0);
    add(0, 4'hF, 4'h0, 4'hD, 1, 1, 4'h0, 1, 3, 0, 1, 0);
    add(0, 4'hF, 4'h0, 4'hD, 0, 0, 4'h8, 0, 3, 0, 1, 0);
    add(0, 4'hF, 4'h0, 4'hD, 0, 0, 4'h0, 0, 3, 0, 0, 0);
    add(0, 4'hF, 4'h0, 4'hD, 1, 1, 4'h0, 1, 0, 0, 1, 0);
    add(0, 4'hF, 4'h0, 4'hD, 0, 0, 4'h1, 0, 0, 0, 1, 0);
    add(0, 4'h0, 4'h0, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    foreach (vq[i]) begin
      @(negedge clk);
      act = {dmaclr, dma_req, dma_sel, dma_burst, busy, tmo};
      exp = {vq[i].clr, vq[i].req, vq[i].sel,
             vq[i].burst, vq[i].busy, vq[i].to};
      ncmp++;
      if (act !== exp) begin
        nfail++;
        $display("FAIL row%0d: got clr/req/sel/burst/busy/to=%b, want %b",
                 i, act, exp);
      end
      rst = vq[i].rst; sreq = vq[i].sreq; breq = vq[i].breq;
      en = vq[i].en; ack = vq[i].ack; done = vq[i].done;
    end

    // holdoff of the served requester, other requester immediate
    do_reset();
    sreq = 4'h4;
    @(negedge clk);
    chk("ho_req0", int'(dma_req), 1);
    chk("ho_sel0", int'(dma_sel), 2);
    ack = 1'b1; done = 1'b1;
    @(negedge clk);
    chk("ho_clr0", int'(dmaclr), 4);
    ack = 1'b0; done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ho_masked", int'(dma_req), 0);
    end
    @(negedge clk);
    chk("ho_regrant", int'(dma_req), 1);
    chk("ho_regrant_sel", int'(dma_sel), 2);
    ack = 1'b1; done = 1'b1;
    @(negedge clk);
    chk("ho_clr1", int'(dmaclr), 4);
    ack = 1'b0; done = 1'b0; sreq = 4'hC;
    @(negedge clk);
    chk("ho_idle", int'(busy), 0);
    @(negedge clk);
    chk("ho_req3", int'(dma_req), 1);
    chk("ho_sel3", int'(dma_sel), 3);
    ack = 1'b1; done = 1'b1;
    @(negedge clk);
    chk("ho_clr3", int'(dmaclr), 8);
    ack = 1'b0; done = 1'b0; sreq = 4'h0;

    // timeout: done never arrives
    do_reset();
    sreq = 4'h1;
    @(negedge clk);
    chk("to_req", int'(dma_req), 1);
    ack = 1'b1; sreq = 4'h0;
    @(negedge clk);
    ack = 1'b0;
    chk("to_xfer_busy", int'(busy), 1);
    chk("to_xfer_req", int'(dma_req), 0);
    for (int k = 3; k <= 9; k++) begin
      @(negedge clk);
      chk("to_low", int'(tmo), 0);
      chk("to_noclr", int'(dmaclr), 0);
    end
    @(negedge clk);
    chk("to_rise", int'(tmo), 1);
    chk("to_rise_noclr", int'(dmaclr), 0);
    @(negedge clk);
    chk("to_clr_pulse", int'(dmaclr), 1);
    chk("to_held", int'(tmo), 1);
    @(negedge clk);
    chk("to_sticky", int'(tmo), 1);
    chk("to_idle", int'(busy), 0);
    tclr = 1'b1;
    @(negedge clk);
    chk("to_cleared", int'(tmo), 0);
    tclr = 1'b0;

    // reset during XFER
    do_reset();
    breq = 4'h2;
    @(negedge clk);
    chk("mr_sel", int'(dma_sel), 1);
    chk("mr_burst", int'(dma_burst), 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("mr_xfer", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_outs", int'({dmaclr, dma_req, dma_sel, dma_burst, busy, tmo}), 0);
    rst = 1'b0; breq = 4'h0; sreq = 4'h6;
    @(negedge clk);
    chk("mr_noclr", int'(dmaclr), 0);
    chk("mr_req", int'(dma_req), 1);
    chk("mr_lowest", int'(dma_sel), 1);
    chk("mr_single", int'(dma_burst), 0);
    ack = 1'b1; done = 1'b1;
    @(negedge clk);
    chk("mr_clr", int'(dmaclr), 2);
    ack = 1'b0; done = 1'b0; sreq = 4'h0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
